data_memory_ctrl: RTL and testbench

//   Next-generation MIPS data memory: word array with byte/halfword/word access, byte enables,

---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/dmem_bank.sv | 34 +++
 rtl/data_memory_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory controller: access size
// encodings, controller FSM states and the byte-lane mask helper.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

    localparam int WORD_BYTES = 4;

    // Byte lanes touched by an access of the given size starting at lane.
    function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << lane;
            SIZE_HALF: mask = 4'b0011 << lane;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data storage: DEPTH_WORDS x 32 bits, per-byte write
// enables and a registered read port.
module dmem_bank
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic [3:0]       write_en,
    input  logic             read_en,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      write_word,
    output logic [31:0]      read_word
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes and registered read of the addressed word.
    // NOTE: the array has no reset branch; clearing a RAM would turn it into
    // flops, and software never relies on power-up contents.
    // NOTE: sequential state uses <= so every reader sees pre-edge values.
    always_ff @(posedge clock) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (write_en[k]) begin
                mem[index][8*k +: 8] <= write_word[8*k +: 8];
            end
        end
        if (read_en) begin
            read_word <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// MIPS data memory controller: valid/ready request, fixed wait-state
// latency, byte/half/word stores and sign/zero-extended loads.
// Optional feature macro MEM_ALIGN_CHECK_EN: when defined, misaligned or
// illegal-size accesses are suppressed and flagged; otherwise the low
// address bits are forced to natural alignment and misaligned is tied 0.
module data_memory_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic                  resp_valid,
    output logic [31:0]           read_data,
    output logic                  misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic             write;
        mem_size_e        size;
        logic             uns;
        logic [IDX_W+1:0] addr;
        logic [31:0]      data;
    } req_t;

    mem_state_e  state, state_nx;
    logic [3:0]  wait_cnt, wait_cnt_nx;
    req_t        live_req, held_req, cur_req;
    mem_size_e   eff_size;
    logic [1:0]  lane;
    logic        align_err;
    logic        commit;
    logic [3:0]  bank_we;
    logic [31:0] bank_wword, bank_rword;
    logic        rd_zero;
    mem_size_e   ld_size;
    logic [1:0]  ld_lane;
    logic        ld_uns;
    logic [31:0] ld_shifted;

    // Upper address bits alias onto the array and are deliberately ignored.
    if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
        logic addr_hi_unused;
        assign addr_hi_unused = ^address[ADDR_WIDTH-1:IDX_W+2];
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    // Bundle the request inputs; with zero wait states the commit edge is the
    // accept edge, so the live request is used while IDLE.
    always_comb begin
        live_req.write = req_write;
        live_req.size  = mem_size_e'(req_size);
        live_req.uns   = req_unsigned;
        live_req.addr  = address[IDX_W+1:0];
        live_req.data  = write_data;
        cur_req        = (state == ST_IDLE) ? live_req : held_req;
    end

    // Next-state logic: IDLE -> BUSY/RESP on a request, BUSY counts wait states.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_cnt_nx = 4'd0;
                if (req_valid) state_nx = (WAIT_STATES > 0) ? ST_BUSY : ST_RESP;
            end
            ST_BUSY: begin
                if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                    state_nx    = ST_RESP;
                    wait_cnt_nx = 4'd0;
                end else begin
                    wait_cnt_nx = wait_cnt + 4'd1;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register, wait counter and request capture.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (req_valid && state == ST_IDLE) held_req <= live_req;
        end
    end

    // Lane selection and alignment check for the request being committed.
    always_comb begin
        eff_size  = cur_req.size;
        lane      = cur_req.addr[1:0];
        align_err = 1'b0;
        case (cur_req.size)
            SIZE_BYTE: lane = cur_req.addr[1:0];
            SIZE_HALF: begin
                lane = {cur_req.addr[1], 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
                align_err = cur_req.addr[0];
`endif
            end
            SIZE_WORD: begin
                lane = 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
                align_err = (cur_req.addr[1:0] != 2'b00);
`endif
            end
            default: begin
                lane     = 2'b00;
                eff_size = SIZE_WORD;
`ifdef MEM_ALIGN_CHECK_EN
                align_err = 1'b1;
`endif
            end
        endcase
    end

    // A reset on the commit edge wins, so the access is dropped entirely.
    assign commit = reset_n && (state != ST_RESP) && (state_nx == ST_RESP);

    // Store data replicated across lanes; the mask picks the live ones.
    always_comb begin
        bank_we = 4'b0000;
        if (commit && cur_req.write && !align_err) bank_we = lane_mask(eff_size, lane);
        case (eff_size)
            SIZE_BYTE: bank_wword = {4{cur_req.data[7:0]}};
            SIZE_HALF: bank_wword = {2{cur_req.data[15:0]}};
            default:   bank_wword = cur_req.data;
        endcase
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clock      (clock),
        .write_en   (bank_we),
        .read_en    (commit && !cur_req.write && !align_err),
        .index      (cur_req.addr[IDX_W+1:2]),
        .write_word (bank_wword),
        .read_word  (bank_rword)
    );

    // Remember how the last load must be steered; stores leave it alone.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_zero <= 1'b1;
            ld_size <= SIZE_WORD;
            ld_lane <= 2'b00;
            ld_uns  <= 1'b0;
        end else if (commit && (!cur_req.write || align_err)) begin
            rd_zero <= align_err;
            ld_size <= eff_size;
            ld_lane <= lane;
            ld_uns  <= cur_req.uns;
        end
    end

    // Right-justify the selected lanes and extend to 32 bits.
    always_comb begin
        ld_shifted = bank_rword >> {ld_lane, 3'b000};
        case (ld_size)
            SIZE_BYTE: read_data = {{24{~ld_uns & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: read_data = {{16{~ld_uns & ld_shifted[15]}}, ld_shifted[15:0]};
            default:   read_data = ld_shifted;
        endcase
        if (rd_zero) read_data = 32'd0;
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;

    // Error flag captured on the commit edge, presented during RESP.
    always_ff @(posedge clock) begin
        if (!reset_n)    mis_q <= 1'b0;
        else if (commit) mis_q <= align_err;
    end

    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: a fast (0 wait) and a slow (3 wait) controller share
// request inputs; a byte-array model predicts every cycle's outputs.
module tb_data_memory_ctrl;

    localparam int DEPTH = 64;
    localparam int NB    = DEPTH * 4;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          u;
        logic [31:0] a;
        logic [31:0] wd;
    } req_s;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rv = 2'b00;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [1:0]  rdy, rsp, mis;
    logic [31:0] rdat [2];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [7:0]  mem_b [2][NB];
    int          resp_in [2] = '{-1, -1};
    logic [31:0] exp_rd [2];
    logic        exp_mis [2];
    req_s        pend [2];
    bit          checking = 0;
    int          cyc = 0;
    bit          acc_flag [2];
    int          acc_cycle [2], resp_cycle [2], resp_cnt [2], busy_cnt [2];
    logic [31:0] last_rd [2];
    logic        last_mis [2];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_fast (
        .clock(clk), .reset_n(reset_n), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .write_data(write_data), .resp_valid(rsp[0]),
        .read_data(rdat[0]), .misaligned(mis[0]));

    data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_slow (
        .clock(clk), .reset_n(reset_n), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .write_data(write_data), .resp_valid(rsp[1]),
        .read_data(rdat[1]), .misaligned(mis[1]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    // Apply a committed access to the byte-array model.
    task automatic model_commit(input int d);
        req_s        r;
        int          nbytes, base;
        logic [31:0] v;
        bit          bad;
        r      = pend[d];
        nbytes = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : 4;
        bad    = 0;
`ifdef MEM_ALIGN_CHECK_EN
        bad = (r.sz == 2'd3) || ((r.a % nbytes) != 0);
`endif
        base = int'(r.a % NB);
        base = base - (base % nbytes);
        exp_mis[d] = bad;
        if (bad) begin
            exp_rd[d] = 32'd0;
        end else if (r.w) begin
            for (int k = 0; k < nbytes; k++) mem_b[d][base+k] = r.wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < nbytes; k++) v = v | (32'(mem_b[d][base+k]) << (8*k));
            if (nbytes < 4 && !r.u && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
            exp_rd[d] = v;
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (resp_in[d] == 0) model_commit(d);
            if (checking) begin
                check($sformatf("req_ready[%0d]", d), 32'(rdy[d]), 32'(resp_in[d] < 0));
                check($sformatf("resp_valid[%0d]", d), 32'(rsp[d]), 32'(resp_in[d] == 0));
                check($sformatf("read_data[%0d]", d), rdat[d], exp_rd[d]);
                if (resp_in[d] == 0)
                    check($sformatf("misaligned[%0d]", d), 32'(mis[d]), 32'(exp_mis[d]));
            end
            if (rsp[d] === 1'b1) resp_cycle[d] = cyc;
            if (rdy[d] === 1'b0) busy_cnt[d]++;
            if (resp_in[d] == 0) begin
                resp_in[d]  = -1;
                resp_cnt[d]++;
                last_rd[d]  = rdat[d];
                last_mis[d] = mis[d];
            end else if (resp_in[d] > 0) begin
                resp_in[d]--;
            end else if (rv[d] && reset_n) begin
                pend[d]      = '{req_write, req_size, req_unsigned, address, write_data};
                resp_in[d]   = ws_of(d);
                acc_flag[d]  = 1;
                acc_cycle[d] = cyc;
                busy_cnt[d]  = 0;
            end
        end
        if (!reset_n) begin
            checking = 1;
            for (int d = 0; d < 2; d++) begin
                resp_in[d]  = -1;
                exp_rd[d]   = 32'd0;
                exp_mis[d]  = 1'b0;
                acc_flag[d] = 0;
            end
        end
    end

    // Present a request, hold it until accepted, then scramble the inputs.
    task automatic issue(input int d, input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        req_write = w; req_size = sz; req_unsigned = u; address = a; write_data = wd;
        rv[d] = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag[d] && n < 64);
        #1;
        if (!acc_flag[d]) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout[%0d]: got no accept, expected accept within 64 cycles", d);
        end
        acc_flag[d] = 0;
        rv[d]       = 1'b0;
        address     = $urandom;
        write_data  = $urandom;
        req_size    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_resp(input int d, input int c0);
        int n = 0;
        while (resp_cnt[d] == c0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (resp_cnt[d] == c0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout[%0d]: got no response, expected one within 64 cycles", d);
        end
    endtask

    task automatic store(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int c0 = resp_cnt[d];
        issue(d, 1'b1, sz, 1'b0, a, wd);
        wait_resp(d, c0);
    endtask

    task automatic load_check(input string name, input int d, input logic [1:0] sz, input bit u,
                              input logic [31:0] a, input logic [31:0] exp);
        int c0 = resp_cnt[d];
        issue(d, 1'b0, sz, u, a, 32'd0);
        wait_resp(d, c0);
        check(name, last_rd[d], exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Fill every word so later loads see defined data.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) store(d, 2'b10, 32'(i * 4), $urandom);

        // Directed sequence on the zero-wait instance.
        store(0, 2'b10, 32'h10, 32'hDEADBEEF);
        load_check("lw_deadbeef", 0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("latency_ws0", 32'(resp_cycle[0] - acc_cycle[0]), 32'd1);
        check("busy_ws0", 32'(busy_cnt[0]), 32'd1);
        store(0, 2'b00, 32'h11, 32'h00000080);
        load_check("lb_sext", 0, 2'b00, 1'b0, 32'h11, 32'hFFFFFF80);
        load_check("lbu_zext", 0, 2'b00, 1'b1, 32'h11, 32'h00000080);
        load_check("lw_after_sb", 0, 2'b10, 1'b0, 32'h10, 32'hDEAD80EF);
        store(0, 2'b01, 32'h12, 32'h00001234);
        load_check("lh", 0, 2'b01, 1'b0, 32'h12, 32'h00001234);
        load_check("lw_after_sh", 0, 2'b10, 1'b0, 32'h10, 32'h123480EF);
        load_check("lw_alias", 0, 2'b10, 1'b0, 32'h10 + 32'(NB) + 32'h8000_0000, 32'h123480EF);
        store(0, 2'b10, 32'h13, 32'hA5A5A5A5);
`ifdef MEM_ALIGN_CHECK_EN
        check("sw_misaligned_flag", 32'(last_mis[0]), 32'd1);
        load_check("lw_after_bad_sw", 0, 2'b10, 1'b0, 32'h10, 32'h123480EF);
`else
        check("sw_misaligned_flag", 32'(last_mis[0]), 32'd0);
        load_check("lw_after_forced_sw", 0, 2'b10, 1'b0, 32'h10, 32'hA5A5A5A5);
`endif

        // Three-wait instance: latency, busy window and reset-abort.
        store(1, 2'b10, 32'h40, 32'hCAFEF00D);
        load_check("lw_ws3", 1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        check("latency_ws3", 32'(resp_cycle[1] - acc_cycle[1]), 32'd4);
        check("busy_ws3", 32'(busy_cnt[1]), 32'd4);
        issue(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        check("rd_after_reset", rdat[1], 32'd0);
        load_check("lw_after_abort", 1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);

        // Randomized traffic, both instances interleaved.
        for (int i = 0; i < 300; i++) begin
            int gap;
            issue(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), $urandom, $urandom);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
